// File: rtl/sobel_window_feeder.sv
// Streams grayscale pixels into two row line buffers and emits one 3-row column
// word per pixel once two full rows have been buffered.
module sobel_window_feeder #(
  parameter int unsigned WIDTH  = 720,
  parameter int unsigned HEIGHT = 540,
  parameter int unsigned XW     = 10,
  parameter int unsigned YW     = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic        in_rd_en,
  input  logic [7:0]  in_dout,
  input  logic        in_empty,
  output logic        out_wr_en,
  output logic [23:0] out_din,
  input  logic        out_full,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StStream,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  // lb0 holds row y-1, lb1 holds row y-2 at each column.
  logic [7:0] lb0 [WIDTH];
  logic [7:0] lb1 [WIDTH];

  logic accept;
  logic last_col;
  logic last_row;

  assign last_col = (x_q == XW'(WIDTH - 1));
  assign last_row = (y_q == YW'(HEIGHT - 1));

  assign accept = !in_empty &&
                  ((state_q == StFill) || ((state_q == StStream) && !out_full));

  assign in_rd_en   = accept;
  assign out_wr_en  = accept && (state_q == StStream);
  assign out_din    = {in_dout, lb0[x_q], lb1[x_q]};
  assign busy       = (state_q == StFill) || (state_q == StStream);
  assign frame_done = (state_q == StDone);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;

    case (state_q)
      StIdle: begin
        if (enable) state_d = StFill;
      end
      StFill: begin
        if (accept && last_col && (y_q == YW'(1))) state_d = StStream;
      end
      StStream: begin
        if (accept && last_col && last_row) state_d = StDone;
      end
      StDone: begin
        state_d = enable ? StFill : StIdle;
        x_d     = '0;
        y_d     = '0;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      if (last_col) begin
        x_d = '0;
        y_d = last_row ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Line buffers are never cleared; reads above see the pre-write contents.
  always_ff @(posedge clock) begin
    if (accept) begin
      lb1[x_q] <= lb0[x_q];
      lb0[x_q] <= in_dout;
    end
  end

endmodule
